// File: rtl/fifo_rd_streamer.sv
// Read-side drain stage for sync_fifo: pops words into a 2-entry skid buffer,
// presents them on a valid/ready stream framed into fixed bursts, and counts deliveries.
module fifo_rd_streamer #(
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_read,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [15:0]      words_sent
);

  localparam int            BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [1:0]       occ_r;
  logic             inflight_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [BW-1:0]    beat_cnt_r;
  logic [15:0]      sent_cnt_r;

  logic             pop_s;
  logic [2:0]       credit_s;

  // Stream outputs decoded straight from registered skid and framing state.
  always_comb begin
    m_valid    = (occ_r != 2'd0);
    m_data     = head_r;
    m_last     = m_valid && (beat_cnt_r == LAST_BEAT);
    words_sent = sent_cnt_r;
    pop_s      = m_valid && m_ready;
  end

  // Read credit: entries held plus the word in flight, less the one leaving this cycle.
  always_comb begin
    credit_s  = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    fifo_read = !reset && !fifo_empty && (credit_s < 3'd2);
  end

  // Skid buffer, in-flight tracking, burst framing and delivered-word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      head_r     <= {WIDTH{1'b0}};
      tail_r     <= {WIDTH{1'b0}};
      beat_cnt_r <= {BW{1'b0}};
      sent_cnt_r <= 16'd0;
    end else begin
      inflight_r <= fifo_read;

      case ({inflight_r, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_r <= fifo_data_out;
          end else begin
            tail_r <= fifo_data_out;
          end
          // Credit keeps occ + inflight <= 2; saturate anyway so occ never encodes 3.
          if (occ_r != 2'd2) begin
            occ_r <= occ_r + 2'd1;
          end
        end
        2'b01: begin
          head_r <= tail_r;
          occ_r  <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            head_r <= fifo_data_out;
          end else begin
            head_r <= tail_r;
            tail_r <= fifo_data_out;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase

      if (pop_s) begin
        beat_cnt_r <= (beat_cnt_r == LAST_BEAT) ? {BW{1'b0}} : beat_cnt_r + BW'(1);
        sent_cnt_r <= sent_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer: a queue-based FIFO source, a scoreboard model
// checked every cycle, and hand-computed expectations for each scenario.
module tb_fifo_rd_streamer;

  localparam int WIDTH     = 16;
  localparam int BURST_LEN = 4;

  logic             clk;
  logic             reset;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_read;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [15:0]      words_sent;

  fifo_rd_streamer #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_read(fifo_read), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .words_sent(words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source FIFO with one-cycle read latency
  logic [15:0] fmem [0:255];
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  wr_ptr = 8'd0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_data_out <= fmem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end

  int          vecs = 0;
  int          errs = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mdl_cnt = 16'd0;
  int          mdl_beat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [15:0] v);
    fmem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(v);
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
    exp_q.delete();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the scoreboard model
  initial begin
    logic        rst_prev;
    logic        stall_prev;
    logic [15:0] held_data;
    logic        held_last;
    logic        exp_last;
    rst_prev   = 1'b0;
    stall_prev = 1'b0;
    held_data  = 16'd0;
    held_last  = 1'b0;
    forever begin
      @(negedge clk);
      chk("rd_when_empty", 32'(fifo_read & fifo_empty), 32'd0);
      chk("occ_plus_inflight", 32'((32'(dut.occ_r) + 32'(dut.inflight_r)) <= 32'd2), 32'd1);
      if (reset) begin
        chk("rd_in_reset", 32'(fifo_read), 32'd0);
      end
      if (rst_prev) begin
        chk("valid_after_rst", 32'(m_valid), 32'd0);
        chk("last_after_rst", 32'(m_last), 32'd0);
        chk("sent_after_rst", 32'(words_sent), 32'd0);
      end
      if (!reset) begin
        if (stall_prev) begin
          chk("stall_valid", 32'(m_valid), 32'd1);
          chk("stall_data", 32'(m_data), 32'(held_data));
          chk("stall_last", 32'(m_last), 32'(held_last));
        end
        chk("words_sent", 32'(words_sent), 32'(mdl_cnt));
        exp_last = m_valid && (mdl_beat == BURST_LEN - 1);
        chk("m_last", 32'(m_last), 32'(exp_last));
        if (m_valid && m_ready) begin
          if (exp_q.size() != 0) begin
            chk("m_data", 32'(m_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
          end else begin
            chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
          end
          mdl_cnt  = mdl_cnt + 16'd1;
          mdl_beat = (mdl_beat + 1) % BURST_LEN;
        end
      end
      stall_prev = !reset && m_valid && !m_ready;
      held_data  = m_data;
      held_last  = m_last;
      rst_prev   = reset;
      if (reset) begin
        mdl_cnt  = 16'd0;
        mdl_beat = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation bound expired (got running, expected finished)");
    $fatal(1);
  end

  initial begin
    int          rds;
    int          n;
    logic        lasts [0:3];
    logic [15:0] sent_seq [0:3];

    // Reset held 3 cycles with data present, then streaming with framing
    reset   = 1'b1;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_rd_in_reset", 32'(fifo_read), 32'd0);
      chk("t1_valid_in_reset", 32'(m_valid), 32'd0);
      chk("t1_last_in_reset", 32'(m_last), 32'd0);
      chk("t1_fifo_has_data", 32'(fifo_empty), 32'd0);
      cyc();
    end
    chk("t1_sent_in_reset", 32'(words_sent), 32'd0);
    reset   = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("t1_rd_first_cycle", 32'(fifo_read), 32'd1);
    chk("t1_valid_c0", 32'(m_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_valid_c1", 32'(m_valid), 32'd0);
    cyc();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("t2_valid", 32'(m_valid), 32'd1);
      chk("t2_data", 32'(m_data), 32'(i));
      chk("t2_last", 32'(m_last), 32'((i % 4) == 0));
      cyc();
    end
    @(negedge clk);
    chk("t2_sent", 32'(words_sent), 32'd8);
    chk("t2_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("t2_valid_end", 32'(m_valid), 32'd0);
    cyc();

    // Backpressure stall
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(16'h00A0 + 16'(i));
    rds = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rds += int'(fifo_read);
      cyc();
    end
    @(negedge clk);
    chk("t3_read_pulses", 32'(rds), 32'd2);
    chk("t3_head", 32'(m_data), 32'h00A0);
    chk("t3_occ", 32'(dut.occ_r), 32'd2);
    chk("t3_valid", 32'(m_valid), 32'd1);
    cyc();
    m_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (exp_q.size() == 0) break;
    end
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    cyc();
    chk("t3_sent", 32'(words_sent), 32'd14);

    // Alternating ready over 16 words
    m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push(16'h4000 + 16'(i));
    for (int k = 0; k < 200; k++) begin
      cyc();
      m_ready = ~m_ready;
      if (exp_q.size() == 0) break;
    end
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    m_ready = 1'b0;
    cyc();
    chk("t4_sent", 32'(words_sent), 32'd30);
    cyc();

    // Counter wrap from a forced preload
    force dut.sent_cnt_r = 16'hFFFE;
    mdl_cnt = 16'hFFFE;
    cyc();
    release dut.sent_cnt_r;
    @(negedge clk);
    chk("t5_preload", 32'(words_sent), 32'h0000_FFFE);
    cyc();
    for (int i = 1; i <= 3; i++) push(16'h5000 + 16'(i));
    cyc();
    cyc();
    cyc();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sent_seq[i] = words_sent;
      cyc();
    end
    chk("t5_seq0", 32'(sent_seq[0]), 32'h0000_FFFE);
    chk("t5_seq1", 32'(sent_seq[1]), 32'h0000_FFFF);
    chk("t5_seq2", 32'(sent_seq[2]), 32'h0000_0000);
    chk("t5_seq3", 32'(sent_seq[3]), 32'h0000_0001);

    // Reset mid-burst with a read in flight
    reset = 1'b1;
    flush();
    cyc();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'h6000 + 16'(i));
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_valid && m_ready) n++;
      cyc();
      if (n == 2) break;
    end
    chk("t6_two_words", 32'(n), 32'd2);
    chk("t6_inflight", 32'(dut.inflight_r), 32'd1);
    reset = 1'b1;
    flush();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_valid_after", 32'(m_valid), 32'd0);
    chk("t6_beat_after", 32'(dut.beat_cnt_r), 32'd0);
    cyc();
    for (int i = 1; i <= 4; i++) push(16'h7000 + 16'(i));
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        lasts[n] = m_last;
        n++;
      end
      cyc();
    end
    chk("t6_refill_count", 32'(n), 32'd4);
    chk("t6_first_last", 32'(lasts[0]), 32'd0);
    chk("t6_fourth_last", 32'(lasts[3]), 32'd1);
    cyc();
    chk("t6_sent", 32'(words_sent), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
